// File: rtl/bg_layer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bg_layer_pkg: shared types and word-field layout for the BG layer. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bg_layer_pkg;

  typedef enum logic [1:0] {
    BG_FG_ONLY = 2'd0,
    BG_KEY     = 2'd1,
    BG_ALPHA   = 2'd2,
    BG_BG_ONLY = 2'd3
  } bg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } bg_state_e;

  // Field slots inside a memory word {b,a,r,g}; bit offset = slot * COLOR_W.
  localparam int unsigned FLD_G = 0;
  localparam int unsigned FLD_R = 1;
  localparam int unsigned FLD_A = 2;
  localparam int unsigned FLD_B = 3;

endpackage
`default_nettype wire

// File: rtl/bg_word_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bg_word_fifo: show-ahead word FIFO with occupancy count and flush.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bg_word_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (PTR_W + 1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop & ~flush & ~empty;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/bg_layer_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bg_layer_fetch: prefetches a background picture from SDRAM and      |
// | composites it with core video. Define BG_ALPHA_BLEND_EN for a true  |
// | alpha mix in mode 2 (otherwise mode 2 keys like mode 1). Rev 1.0    |
// +--------------------------------------------------------------------+
module bg_layer_fetch
  import bg_layer_pkg::*;
#(
  parameter int                ADDR_W     = 25,
  parameter int                COLOR_W    = 4,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 vs,
  input  logic                 bg_enable,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_rd,
  input  logic [4*COLOR_W-1:0] mem_dout,
  input  logic                 mem_valid,
  output logic [3*COLOR_W-1:0] rgb_out,
  output logic                 underflow
);
  localparam int WORD_W = 4 * COLOR_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  bg_state_e            state_q, state_d;
  logic                 vs_prev_q, vs_prev_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 outstanding_q, outstanding_d;
  logic                 discard_q, discard_d;
  logic                 underflow_q, underflow_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;

  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [WORD_W-1:0]    fifo_rdata;
  logic                 vs_rise, flush, pop_req, fifo_pop, fifo_push, issue;
  logic [WORD_W-1:0]    pop_word;
  logic [COLOR_W-1:0]   bg_a;
  logic [3*COLOR_W-1:0] bg_rgb, key_rgb, alpha_rgb;

  bg_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .push    (fifo_push),
    .wr_data (mem_dout),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    vs_prev_d     = ce_pix ? vs : vs_prev_q;
    addr_d        = addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    underflow_d   = underflow_q;

    vs_rise   = ce_pix & vs & ~vs_prev_q;
    flush     = bg_enable & vs_rise;
    pop_req   = bg_enable & (state_q == ST_RUN) & ce_pix & ~hblank & ~vblank & ~flush;
    fifo_pop  = pop_req & ~fifo_empty;
    fifo_push = mem_valid & outstanding_q & ~discard_q;
    issue     = bg_enable & (state_q != ST_IDLE) & ~flush
              & ~outstanding_q & ~discard_q
              & ((fifo_count + CNT_W'(outstanding_q | discard_q)) < CNT_W'(FIFO_DEPTH));
    mem_rd_d  = issue;

    if (!bg_enable)                                 state_d = ST_IDLE;
    else if (vs_rise)                               state_d = ST_FILL;
    else if ((state_q == ST_FILL) && fifo_full)     state_d = ST_RUN;

    // Address is presented with the strobe and advances once it has been seen.
    if (mem_rd_q) addr_d = addr_q + ADDR_W'(2);
    if (mem_valid && (outstanding_q || discard_q)) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
    end
    if (issue) outstanding_d = 1'b1;
    if (pop_req && fifo_empty) underflow_d = 1'b1;

    if (flush) begin
      addr_d        = BASE_ADDR;
      discard_d     = (outstanding_q | discard_q) & ~mem_valid;
      outstanding_d = 1'b0;
      underflow_d   = 1'b0;
    end
  end

  always_comb begin
    pop_word = fifo_empty ? '0 : fifo_rdata;
    bg_a     = pop_word[FLD_A*COLOR_W +: COLOR_W];
    bg_rgb   = {pop_word[FLD_R*COLOR_W +: COLOR_W],
                pop_word[FLD_G*COLOR_W +: COLOR_W],
                pop_word[FLD_B*COLOR_W +: COLOR_W]};
    key_rgb  = ((fg_rgb != '0) && (bg_a == '0)) ? fg_rgb : bg_rgb;
  end

`ifdef BG_ALPHA_BLEND_EN
  // fg*(M-a) + bg*a rewritten as fg*M +/- |bg-fg|*a: one product per channel.
  for (genvar c = 0; c < 3; c++) begin : g_blend
    logic [COLOR_W-1:0]   fg_c, bg_c, diff_c;
    logic [2*COLOR_W-1:0] prod_c;
    logic [2*COLOR_W:0]   base_c, mix_c;
    logic                 unused_mix;
    assign fg_c   = fg_rgb[c*COLOR_W +: COLOR_W];
    assign bg_c   = bg_rgb[c*COLOR_W +: COLOR_W];
    assign diff_c = (bg_c >= fg_c) ? (bg_c - fg_c) : (fg_c - bg_c);
    assign prod_c = (2*COLOR_W)'(diff_c) * (2*COLOR_W)'(bg_a);
    assign base_c = {1'b0, fg_c, {COLOR_W{1'b0}}} - (2*COLOR_W+1)'(fg_c);
    assign mix_c  = (bg_c >= fg_c) ? (base_c + (2*COLOR_W+1)'(prod_c))
                                   : (base_c - (2*COLOR_W+1)'(prod_c));
    assign alpha_rgb[c*COLOR_W +: COLOR_W] = mix_c[2*COLOR_W-1:COLOR_W];
    assign unused_mix = ^{mix_c[2*COLOR_W], mix_c[COLOR_W-1:0]};
  end
`else
  assign alpha_rgb = key_rgb;
`endif

  always_comb begin
    rgb_d = rgb_q;
    if (ce_pix) begin
      if (pop_req) begin
        case (bg_mode_e'(mode))
          BG_FG_ONLY: rgb_d = fg_rgb;
          BG_KEY:     rgb_d = key_rgb;
          BG_ALPHA:   rgb_d = alpha_rgb;
          BG_BG_ONLY: rgb_d = bg_rgb;
          default:    rgb_d = fg_rgb;
        endcase
      end else begin
        rgb_d = (bg_mode_e'(mode) == BG_BG_ONLY) ? '0 : fg_rgb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      vs_prev_q     <= 1'b0;
      addr_q        <= BASE_ADDR;
      mem_rd_q      <= 1'b0;
      outstanding_q <= 1'b0;
      // A read still in flight must not land in the FIFO after reset.
      discard_q     <= (outstanding_q | discard_q) & ~mem_valid;
      underflow_q   <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      vs_prev_q     <= vs_prev_d;
      addr_q        <= addr_d;
      mem_rd_q      <= mem_rd_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      underflow_q   <= underflow_d;
      rgb_q         <= rgb_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd    = mem_rd_q;
  assign rgb_out   = rgb_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_layer_fetch.sv
`default_nettype none
// Bench for bg_layer_fetch; expectations follow BG_ALPHA_BLEND_EN when defined.
module tb_bg_layer_fetch;
  import bg_layer_pkg::*;

  localparam int                ADDR_W     = 25;
  localparam int                COLOR_W    = 4;
  localparam int                FIFO_DEPTH = 8;
  localparam logic [ADDR_W-1:0] BASE_ADDR  = '0;
`ifdef BG_ALPHA_BLEND_EN
  localparam bit BLEND = 1'b1;
`else
  localparam bit BLEND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, ce_pix, hblank, vblank, vs, bg_enable;
  logic [1:0]        mode;
  logic [11:0]       fg_rgb;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_dout;
  logic              mem_valid;
  logic [11:0]       rgb_out;
  logic              underflow;

  always #5 clk = ~clk;

  bg_layer_fetch #(
    .ADDR_W     (ADDR_W),
    .COLOR_W    (COLOR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .hblank    (hblank),
    .vblank    (vblank),
    .vs        (vs),
    .bg_enable (bg_enable),
    .mode      (mode),
    .fg_rgb    (fg_rgb),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_dout  (mem_dout),
    .mem_valid (mem_valid),
    .rgb_out   (rgb_out),
    .underflow (underflow)
  );

  // Memory model: fixed latency, response can be held off.
  logic [15:0]       mem_img [0:63];
  int                resp_timer = -1;
  logic [ADDR_W-1:0] resp_addr  = '0;
  logic              mem_hold   = 1'b0;
  logic [ADDR_W-1:0] req_log [$];
  int                proto_err  = 0;

  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (resp_timer == 0 && !mem_hold) begin
      mem_valid  = 1'b1;
      mem_dout   = mem_img[resp_addr[6:1]];
      resp_timer = -1;
    end else if (resp_timer > 0) begin
      resp_timer--;
    end
    if (mem_rd === 1'b1) begin
      if (resp_timer >= 0) proto_err++;
      req_log.push_back(mem_addr);
      resp_addr  = mem_addr;
      resp_timer = 2;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    ce_pix = 1'b1; hblank = 1'b1; vblank = 1'b1; vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (dut.state_q != ST_RUN && n < budget) begin
      tick();
      n++;
    end
    check("reach_run", 32'(dut.state_q == ST_RUN), 32'd1);
  endtask

  task automatic pop_check(input string name, input logic [11:0] exp);
    ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0;
    tick();
    ce_pix = 1'b0;
    check(name, 32'(rgb_out), 32'(exp));
  endtask

  task automatic fill_all(input logic [15:0] w);
    for (int i = 0; i < 64; i++) mem_img[i] = w;
  endtask

  task automatic fill_idx();
    for (int i = 0; i < 64; i++) mem_img[i] = {4'hC, 4'h0, 4'(i), 4'h1};
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] fg;
    logic [15:0] word;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Word layout {b,a,r,g}; output {r,g,b}.
    vecs[0] = '{2'd1, 12'h000, 16'hF0A5, 12'hA5F};
    vecs[1] = '{2'd0, 12'h123, 16'hF0A5, 12'h123};
    vecs[2] = '{2'd3, 12'h123, 16'hF0A5, 12'hA5F};
    vecs[3] = '{2'd1, 12'h123, 16'h3042, 12'h123};
    vecs[4] = '{2'd1, 12'h123, 16'h3142, 12'h423};
    vecs[5] = '{2'd2, 12'hF00, 16'h0800, BLEND ? 12'h600 : 12'h000};
    vecs[6] = '{2'd2, 12'h000, 16'h5073, BLEND ? 12'h000 : 12'h735};
    vecs[7] = '{2'd2, 12'h8C4, 16'hFFF8, BLEND ? 12'hE7E : 12'hF8F};
    vecs[8] = '{2'd2, 12'h4A2, 16'h6579, BLEND ? 12'h493 : 12'h796};
    vecs[9] = '{2'd3, 12'hABC, 16'h0000, 12'h000};

    reset = 1'b1; ce_pix = 1'b0; hblank = 1'b0; vblank = 1'b0; vs = 1'b0;
    bg_enable = 1'b0; mode = 2'd0; fg_rgb = 12'h000;
    fill_all(16'h0000);
    repeat (3) tick();
    check("rst_mem_addr",  32'(mem_addr), 32'(BASE_ADDR));
    check("rst_mem_rd",    32'(mem_rd), 32'd0);
    check("rst_rgb_out",   32'(rgb_out), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;
    tick();

    // Initial fill: eight reads at 0,2,...,14.
    bg_enable = 1'b1; mode = 2'd3;
    fill_all(16'hF0A5);
    req_log.delete();
    vs_pulse();
    wait_run(300);
    repeat (10) tick();
    check("fill_read_count", 32'(req_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("fill_addr%0d", i), (i < req_log.size()) ? 32'(req_log[i]) : 32'hFFFF_FFFF, 32'(i * 2));
    check("fill_underflow", 32'(underflow), 32'd0);

    for (int i = 0; i < 10; i++) begin
      fill_all(vecs[i].word);
      mode   = vecs[i].mode;
      fg_rgb = vecs[i].fg;
      vs_pulse();
      wait_run(300);
      pop_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Blanking and idle pass-through.
    mode = 2'd0; fg_rgb = 12'h321; ce_pix = 1'b1; hblank = 1'b1;
    tick();
    check("hblank_mode0", 32'(rgb_out), 32'h321);
    mode = 2'd3;
    tick();
    check("hblank_mode3", 32'(rgb_out), 32'h000);
    ce_pix = 1'b0; hblank = 1'b0;
    bg_enable = 1'b0; mode = 2'd1; fg_rgb = 12'h456;
    tick();
    check("idle_state", 32'(dut.state_q == ST_IDLE), 32'd1);
    pop_check("idle_mode1", 12'h456);
    mode = 2'd3;
    pop_check("idle_mode3", 12'h000);
    bg_enable = 1'b1;

    // Underflow: memory stalled while popping every pixel.
    fill_all(16'hFFFF);
    mode = 2'd3;
    vs_pulse();
    wait_run(300);
    mem_hold = 1'b1;
    pop_check("uf_first_pop", 12'hFFF);
    ce_pix = 1'b1;
    repeat (20) tick();
    ce_pix = 1'b0;
    check("uf_flag", 32'(underflow), 32'd1);
    check("uf_rgb_zero", 32'(rgb_out), 32'h000);
    mem_hold = 1'b0;
    repeat (6) tick();
    check("uf_sticky", 32'(underflow), 32'd1);
    vs_pulse();
    check("uf_cleared_by_vs", 32'(underflow), 32'd0);
    wait_run(300);

    // vs while a read is outstanding: stale word dropped, restart at base.
    fill_idx();
    vs_pulse();
    wait_run(300);
    mem_hold = 1'b1;
    pop_check("idx_first", 12'h01C);
    repeat (3) tick();
    req_log.delete();
    vs_pulse();
    repeat (5) tick();
    check("no_req_while_discard", 32'(req_log.size()), 32'd0);
    mem_hold = 1'b0;
    wait_run(300);
    check("req_after_flush", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF, 32'(BASE_ADDR));
    pop_check("stale_dropped", 12'h01C);

    // Reset in RUN with a read pending.
    mem_hold = 1'b1;
    pop_check("pre_reset_pop", 12'h11C);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midrst_mem_addr",  32'(mem_addr), 32'(BASE_ADDR));
    check("midrst_mem_rd",    32'(mem_rd), 32'd0);
    check("midrst_rgb_out",   32'(rgb_out), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
    reset = 1'b0;
    mem_hold = 1'b0;
    repeat (6) tick();
    check("late_valid_no_push", 32'(dut.u_fifo.count), 32'd0);
    req_log.delete();
    vs_pulse();
    wait_run(300);
    check("post_rst_req", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF, 32'(BASE_ADDR));
    pop_check("post_rst_pop", 12'h01C);

    check("one_outstanding", 32'(proto_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
